// File: rtl/mips_cpu_divider_pkg.sv
// Shared types and constants for the iterative restoring divider.
package mips_cpu_divider_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIX
  } div_state_t;

  // Selects how the FIX cycle forms its results.
  typedef enum logic [1:0] {
    OP_DIV,
    OP_DBZ,
    OP_EARLY
  } div_op_t;

endpackage

// File: rtl/mips_cpu_divider_step.sv
// One restoring radix-2 step: shift in the next dividend bit, subtract the
// divisor if it fits, and report the resulting quotient bit.
module mips_cpu_divider_step
  import mips_cpu_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] dvs_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] shifted;
  logic           fits;

  // The partial remainder is always below the divisor, so the restored or
  // reduced value always fits back into WIDTH bits.
  assign shifted = {rem_i, bit_i};
  assign fits    = (shifted >= {1'b0, dvs_i});
  assign rem_o   = fits ? (shifted[WIDTH-1:0] - dvs_i) : shifted[WIDTH-1:0];
  assign q_o     = fits;

endmodule

// File: rtl/mips_cpu_divider_param.sv
// Multi-cycle signed/unsigned restoring divider, one quotient bit per cycle.
// Optional MIPS_CPU_DIVIDER_EARLY_OUT_EN skips iteration when |Dividend| < |Divisor|.
module mips_cpu_divider_param
  import mips_cpu_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             done,
  output logic             busy,
  output logic             dbz
);

  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  function automatic logic [WIDTH-1:0] sign_fix(input logic [WIDTH-1:0] v,
                                                input logic             neg);
    return neg ? -v : v;
  endfunction

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH-1:0] shf_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvd_raw_q;
  logic             qneg_q;
  logic             rneg_q;
  div_op_t          op_q;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             div_zero;
  logic             early_out;
  logic             accept;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic [WIDTH-1:0] fix_quo, fix_rem;

  assign a_neg    = is_signed & Dividend[WIDTH-1];
  assign b_neg    = is_signed & Divisor[WIDTH-1];
  assign a_mag    = sign_fix(Dividend, a_neg);
  assign b_mag    = sign_fix(Divisor, b_neg);
  assign div_zero = (Divisor == '0);
  assign accept   = start && (state_q == IDLE);

`ifdef MIPS_CPU_DIVIDER_EARLY_OUT_EN
  assign early_out = !div_zero && (a_mag < b_mag);
`else
  assign early_out = 1'b0;
`endif

  mips_cpu_divider_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_i (rem_q),
    .dvs_i (dvs_q),
    .bit_i (shf_q[WIDTH-1]),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = (div_zero || early_out) ? FIX : ITER;
      ITER: if (cnt_q == LAST_CNT) state_d = FIX;
      FIX:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Shortcut operations report the raw dividend as remainder.
  always_comb begin
    fix_quo = sign_fix(shf_q, qneg_q);
    fix_rem = sign_fix(rem_q, rneg_q);
    unique case (op_q)
      OP_DBZ: begin
        fix_quo = '1;
        fix_rem = dvd_raw_q;
      end
      OP_EARLY: begin
        fix_quo = '0;
        fix_rem = dvd_raw_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dbz       <= 1'b0;
      Quotient  <= '0;
      Remainder <= '0;
    end else begin
      state_q <= state_d;
      done    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            cnt_q <= '0;
          end
        end
        ITER: cnt_q <= cnt_q + CNT_ONE;
        FIX: begin
          busy      <= 1'b0;
          done      <= 1'b1;
          cnt_q     <= '0;
          dbz       <= (op_q == OP_DBZ);
          Quotient  <= fix_quo;
          Remainder <= fix_rem;
        end
        default: ;
      endcase
    end
  end

  // shf_q starts as the dividend magnitude and fills with quotient bits.
  always_ff @(posedge clk) begin
    if (accept) begin
      shf_q     <= a_mag;
      dvs_q     <= b_mag;
      rem_q     <= '0;
      qneg_q    <= a_neg ^ b_neg;
      rneg_q    <= a_neg;
      dvd_raw_q <= Dividend;
      op_q      <= div_zero ? OP_DBZ : (early_out ? OP_EARLY : OP_DIV);
    end else if (state_q == ITER) begin
      shf_q <= {shf_q[WIDTH-2:0], step_q};
      rem_q <= step_rem;
    end
  end

endmodule

// File: tb/tb_mips_cpu_divider_param.sv
// Scoreboard bench for mips_cpu_divider_param (WIDTH=32) with a longint reference model.
module tb_mips_cpu_divider_param;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         start;
  logic         is_signed;
  logic [W-1:0] Dividend;
  logic [W-1:0] Divisor;
  logic [W-1:0] Quotient;
  logic [W-1:0] Remainder;
  logic         done;
  logic         busy;
  logic         dbz;

  mips_cpu_divider_param #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .Dividend  (Dividend),
    .Divisor   (Divisor),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .done      (done),
    .busy      (busy),
    .dbz       (dbz)
  );

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           lat;
    int           due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, req, cyc);
  endtask

  function automatic longint labs(input longint v);
    return (v < 0) ? -v : v;
  endfunction

  // Truncating division straight from the arithmetic definition.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
    exp_t   e;
    longint sa, sb_, q, r;
    e.due = 0;
    if (b == '0) begin
      e.q = '1; e.r = a; e.dbz = 1'b1; e.lat = 2;
    end else begin
      if (sgn) begin
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
      end else begin
        sa  = longint'({32'd0, a});
        sb_ = longint'({32'd0, b});
      end
      q = sa / sb_;
      r = sa % sb_;
      e.q = q[W-1:0];
      e.r = r[W-1:0];
      e.dbz = 1'b0;
      e.lat = W + 2;
`ifdef MIPS_CPU_DIVIDER_EARLY_OUT_EN
      if (labs(sa) < labs(sb_)) e.lat = 2;
`endif
    end
    return e;
  endfunction

  // Monitor: checks every done pulse against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (done) begin
        if (sb.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          chk("quotient", Quotient, e.q);
          chk("remainder", Remainder, e.r);
          chk("dbz", {31'd0, dbz}, {31'd0, e.dbz});
          chk("done_cycle", cyc, e.due);
          chk("busy_at_done", {31'd0, busy}, 32'd0);
        end
      end else if (sb.size() > 0) begin
        if (cyc > sb[0].due) begin
          chk("done_timeout", cyc, sb[0].due);
          void'(sb.pop_front());
        end else begin
          chk("busy_in_flight", {31'd0, busy}, 32'd1);
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
    exp_t e;
    int   c0;
    wait_idle();
    Dividend  = a;
    Divisor   = b;
    is_signed = sgn;
    start     = 1'b1;
    c0        = cyc;
    @(posedge clk);
    e     = model(a, b, sgn);
    e.due = c0 + e.lat;
    sb.push_back(e);
    @(negedge clk);
    start    = 1'b0;
    Dividend = $urandom;
    Divisor  = $urandom;
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_quotient"}, Quotient, '0);
    chk({tag, "_remainder"}, Remainder, '0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_dbz"}, {31'd0, dbz}, 32'd0);
  endtask

  initial begin
    logic [W-1:0] a, b;
    logic         s;
    int           n;
    reset = 1'b0; start = 1'b0; is_signed = 1'b0; Dividend = '0; Divisor = '0;
    repeat (3) @(negedge clk);
    check_cleared("reset");
    reset = 1'b1;
    @(negedge clk);

    issue(32'd7, 32'd2, 1'b0);
    issue(32'hFFFF_FFF9, 32'd2, 1'b1);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    issue(32'd5, 32'd0, 1'b0);
    issue(32'd0, 32'd2, 1'b0);
    issue(32'd3, 32'd10, 1'b0);
    issue(32'd7, 32'hFFFF_FFFE, 1'b1);
    issue(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1);
    issue(32'hFFFF_FFF9, 32'd2, 1'b0);
    issue(32'hFFFF_FFFF, 32'd1, 1'b0);

    // start while busy and start during the FIX cycle must both be ignored
    issue(32'd100, 32'd7, 1'b0);
    repeat (8) @(negedge clk);
    Dividend = 32'd9; Divisor = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (sb.size() > 0 && cyc < sb[0].due - 1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    Dividend = 32'd9; Divisor = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("fix_start_ignored", {31'd0, busy}, 32'd0);

    // reset mid-operation aborts silently
    issue(32'd100, 32'd7, 1'b0);
    repeat (8) @(negedge clk);
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    check_cleared("abort");
    issue(32'd9, 32'd3, 1'b0);

    for (int i = 0; i < 60; i++) begin
      s = $urandom_range(0, 1);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: ;
        1: b = $urandom_range(1, 15);
        2: b = '0;
        3: begin a = 32'h8000_0000; if ($urandom_range(0, 1) == 1) b = '1; end
        4: begin a = $urandom_range(0, 20); b = $urandom_range(1, 40); end
        default: b = b >> $urandom_range(0, 31);
      endcase
      issue(a, b, s);
    end

    repeat (60) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mips_cpu_divider_param.md
MIPS_CPU_DIVIDER_PARAM -- requirements
Module: mips_cpu_divider_param

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits (>= 4).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; sampled on rising clk edge.
REQ-004 start  input  1  request a division; accepted only when idle.
REQ-005 is_signed  input  1  1 = two's-complement division, 0 = unsigned; captured on accept.
REQ-006 Dividend  input  WIDTH  dividend; captured on accept.
REQ-007 Divisor  input  WIDTH  divisor; captured on accept.
REQ-008 Quotient  output  WIDTH  result quotient.
REQ-009 Remainder  output  WIDTH  result remainder.
REQ-010 done  output  1  one-cycle pulse marking valid results.
REQ-011 busy  output  1  high while an operation is in flight.
REQ-012 dbz  output  1  divide-by-zero flag for the last operation.

Function
REQ-013 States SHALL be IDLE, ITER, FIX; accept = rising edge with start=1 and state IDLE.
REQ-014 On accept, operand magnitudes, sign bits and is_signed SHALL be registered; state -> ITER; busy=1; done=0.
REQ-015 ITER SHALL perform one restoring radix-2 step per cycle, exactly WIDTH cycles, via an iteration counter; then -> FIX.
REQ-016 FIX SHALL write sign-corrected Quotient/Remainder, pulse done for exactly one cycle, clear busy, return to IDLE.
REQ-017 Latency: accept at edge k -> done high in the cycle after edge k+WIDTH+1.
REQ-018 Signed: quotient negated when operand signs differ; remainder takes dividend sign (truncating division).
REQ-019 Signed MIN / -1 SHALL yield Quotient=MIN, Remainder=0, dbz=0.
REQ-020 Divisor=0 on accept: dbz=1, Quotient=all ones, Remainder=Dividend, done pulsed in cycle after edge k+1; ITER skipped.
REQ-021 start while busy SHALL be ignored; in-flight operation unaffected.
REQ-022 start sampled in the FIX cycle SHALL be ignored; earliest new accept is the edge ending the done cycle.
REQ-023 Quotient, Remainder, dbz SHALL hold their values until the next FIX/dbz completion.

Reset
REQ-024 reset=0 at a rising edge SHALL force IDLE; Quotient=0, Remainder=0, done=0, busy=0, dbz=0, counter=0.
REQ-025 Reset mid-operation SHALL abort with no done pulse; reset has priority over start.

Configuration
REQ-026 Macro MIPS_CPU_DIVIDER_EARLY_OUT_EN defined: on accept, if |Dividend| < |Divisor| (nonzero divisor), ITER SHALL be skipped; Quotient=0, Remainder=Dividend, done in cycle after edge k+1.
REQ-027 Macro undefined: every nonzero-divisor operation takes the full WIDTH+2 latency of REQ-017.

Structure
REQ-028 Package mips_cpu_divider_pkg SHALL hold the state enum (IDLE, ITER, FIX) and the default-width constant.
REQ-029 One combinational sub-module mips_cpu_divider_step SHALL implement a single restoring step (partial remainder, divisor, next dividend bit -> new remainder, quotient bit).
REQ-030 Counter width SHALL be $clog2(WIDTH+1) bits.

Verification (WIDTH=32)
REQ-031 Unsigned 7/2, start one cycle -> done after 34 edges, Quotient=3, Remainder=1, dbz=0, busy high throughout.
REQ-032 Signed -7/2 -> Quotient=-3 (0xFFFFFFFD), Remainder=-1; signed 0x80000000/-1 -> Quotient=0x80000000, Remainder=0.
REQ-033 5/0 -> dbz=1, Quotient=0xFFFFFFFF, Remainder=5, done after 2 edges; next 0/2 -> Quotient=0, Remainder=0, dbz=0.
REQ-034 Start 100/7, re-pulse start with 9/3 at cycle 10 -> single done, Quotient=14, Remainder=2.
REQ-035 Start 100/7, reset=0 at cycle 10 -> no done, all outputs 0; new 9/3 afterwards -> Quotient=3, Remainder=0.
REQ-036 With MIPS_CPU_DIVIDER_EARLY_OUT_EN: 3/10 -> done after 2 edges, Quotient=0, Remainder=3; without it, after 34 edges, same values.
